// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one instruction at a time over a
// request/valid handshake and steps to PC+4 or to a redirect target when the instruction retires.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_WAIT  = 15,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_ERR
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] next_pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign next_pc = redirect ? target : pc_q + 32'd4;

    // NOTE: every signal gets a hold-value default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        wait_cnt_d    = wait_cnt_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_VALID;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_VALID: begin
                // Redirect and target only matter on the retire cycle; stall wins.
                if (!stall) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    if (next_pc[1:0] != 2'b00) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERR;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == S_REQ);
        imem_addr   = pc_q;
        instr       = instr_q;
        instr_valid = instr_valid_q;
        pc          = pc_q;
        pc_plus4    = pc_q + 32'd4;
        fetch_err   = fetch_err_q;
    end

endmodule
